// File: rtl/dmx16_64bits_hs.sv
// 1-to-16 registered demultiplexer with valid/ready handshake.
// One holding register; destination from sel or a round-robin pointer.
module dmx16_64bits_hs #(
  parameter int WIDTH = 64,
  parameter int NCH   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic             auto_mode,
  output logic [WIDTH-1:0] out_data,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [3:0]       rr_ptr,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [3:0]       dest;
  logic [3:0]       nxt_dest;
  logic [NCH-1:0]   nxt_oh;
  logic             accept;
  logic             deliver;

  assign deliver  = (state == FULL) && out_ready[dest];
  assign in_ready = (state == EMPTY) || out_ready[dest];
  assign accept   = in_valid && in_ready;
  assign nxt_dest = auto_mode ? rr_ptr : sel;

  always_comb begin
    nxt_oh = '0;
    nxt_oh[nxt_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      dest      <= '0;
      out_data  <= '0;
      out_valid <= '0;
      rr_ptr    <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (deliver)
        xfer_cnt <= xfer_cnt + 16'd1;
      if (accept) begin
        out_data  <= in_data;
        dest      <= nxt_dest;
        out_valid <= nxt_oh;
        if (auto_mode)
          rr_ptr <= rr_ptr + 4'd1;
      end
      unique case (state)
        EMPTY: begin
          if (accept)
            state <= FULL;
        end
        FULL: begin
          // reload keeps FULL; drain without reload empties
          if (deliver && !accept) begin
            state     <= EMPTY;
            out_valid <= '0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_dmx16_64bits_hs.sv
// Randomized bench for dmx16_64bits_hs against a queue-based model.
// Directed scenarios plus random traffic and counter wrap.
module tb_dmx16_64bits_hs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic [3:0]  sel;
  logic        auto_mode;
  logic [63:0] out_data;
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [3:0]  rr_ptr;
  logic [15:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    int          c;
  } ent_t;

  ent_t        q[$];
  int          m_rr;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  dmx16_64bits_hs dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sel       (sel),
    .auto_mode (auto_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    q.delete();
    m_rr  = 0;
    m_cnt = 16'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_od"}, out_data, 0);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_rr"}, rr_ptr, 0);
    chk({tag, "_cnt"}, xfer_cnt, 0);
  endtask

  // drive one cycle, compare against model, then advance model
  task automatic cyc(input logic v, input logic [63:0] d,
                     input logic [3:0] s, input logic am,
                     input logic [15:0] r);
    logic        e_rdy;
    logic [15:0] e_ov;
    logic        acc;
    logic        del;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    sel       = s;
    auto_mode = am;
    out_ready = r;
    #1;
    e_ov  = 16'h0;
    e_rdy = 1'b1;
    del   = 1'b0;
    if (q.size() != 0) begin
      e_ov = 16'h1 << q[0].c;
      e_rdy = r[q[0].c];
      del = r[q[0].c];
      chk("out_data", out_data, q[0].d);
    end
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_ov);
    chk("rr_ptr", rr_ptr, m_rr);
    chk("xfer_cnt", xfer_cnt, m_cnt);
    acc = v && e_rdy;
    @(posedge clk);
    if (del) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (acc) begin
      q.push_back('{d: d, c: am ? m_rr : int'(s)});
      if (am) m_rr = (m_rr + 1) % 16;
    end
  endtask

  task automatic idle(input logic [15:0] r);
    cyc(1'b0, 64'hDEAD_BEEF_0BAD_F00D, 4'($urandom), 1'($urandom), r);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    m_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = '0;
    auto_mode = 1'b0;
    out_ready = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;

    // direct single transfer to channel 5
    cyc(1'b1, 64'h0123456789ABCDEF, 4'd5, 1'b0, 16'h0);
    cyc(1'b0, 64'h0, 4'd0, 1'b0, 16'h0);
    chk("d5_ov", out_valid, 16'h0020);
    chk("d5_od", out_data, 64'h0123456789ABCDEF);
    idle(16'h0020);
    idle(16'h0);
    chk("d5_empty", out_valid, 16'h0);
    chk("d5_cnt", xfer_cnt, 16'd1);

    // round-robin wrap after reset
    rst_pulse();
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, {$urandom, $urandom}, 4'($urandom), 1'b1, 16'hFFFF);
      if (i > 0) chk("rr_seq", out_valid, 16'h1 << ((i - 1) % 16));
    end
    idle(16'hFFFF);
    idle(16'hFFFF);
    chk("rr_ptr_end", rr_ptr, 4'd1);
    chk("rr_cnt17", xfer_cnt, 16'd17);

    // backpressure isolation on channel 3
    cyc(1'b1, 64'hA5A5_0000_3333_5A5A, 4'd3, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, {$urandom, $urandom}, 4'($urandom), 1'b0, 16'hFFF7);
    chk("bp_ov", out_valid, 16'h0008);
    chk("bp_od", out_data, 64'hA5A5_0000_3333_5A5A);
    idle(16'h0008);
    idle(16'h0);

    // simultaneous deliver and accept
    cyc(1'b1, 64'h2222, 4'd2, 1'b0, 16'h0);
    cyc(1'b1, 64'h9999, 4'd9, 1'b0, 16'h0004);
    idle(16'h0);
    chk("sim_ov", out_valid, 16'h0200);
    chk("sim_od", out_data, 64'h9999);
    idle(16'h0200);

    // mid-operation reset while holding channel 7
    cyc(1'b1, 64'h7777, 4'd7, 1'b0, 16'h0);
    idle(16'h0);
    chk("mr_ov", out_valid, 16'h0080);
    rst_pulse();
    cyc(1'b1, 64'h1234, 4'd9, 1'b1, 16'h0);
    idle(16'h0);
    chk("post_rst_ch0", out_valid, 16'h0001);
    idle(16'h0001);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
          4'($urandom), 1'($urandom), r);
    end

    // counter wrap
    rst_pulse();
    for (int i = 0; i < 65536; i++)
      cyc(1'b1, {$urandom, $urandom}, 4'd0, 1'b1, 16'hFFFF);
    idle(16'hFFFF);
    idle(16'hFFFF);
    chk("wrap_cnt", xfer_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
